// File: rtl/rf_readout_pkg.sv
// rtl/rf_readout_pkg.sv - shared sizes and state encoding for the register-file readout streamer
package rf_readout_pkg;

    localparam int RF_REG_COUNT    = 16;
    localparam int RF_REG_SIZE     = 32;
    localparam int RF_REG_PTR_SIZE = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_CSUM   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/rf_readout.sv
// rtl/rf_readout.sv - register-file readout streamer; RF_READOUT_CSUM_EN appends an XOR checksum word
module rf_readout
    import rf_readout_pkg::*;
#(
    parameter int REG_COUNT    = RF_REG_COUNT,
    parameter int REG_SIZE     = RF_REG_SIZE,
    parameter int REG_PTR_SIZE = RF_REG_PTR_SIZE
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    rf_hold,
    output logic [REG_PTR_SIZE-1:0] rd_ptr,
    input  logic [REG_SIZE-1:0]     rd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [REG_SIZE-1:0]     out_data,
    output logic [REG_PTR_SIZE-1:0] out_idx,
    output logic                    out_last,
    output logic                    out_is_csum
);

    localparam logic [REG_PTR_SIZE-1:0] LAST_PTR = REG_PTR_SIZE'(REG_COUNT - 1);

    logic [1:0] state;
    logic       loaded_all;
    logic       fire;
    logic       load;

`ifdef RF_READOUT_CSUM_EN
    logic [REG_SIZE-1:0] csum;
    logic                is_csum_q;
`endif

    // Handshake and load qualifiers; a load refills the holding register as the old word leaves
    always_comb begin
        fire = out_valid & out_ready;
        load = (state == ST_STREAM) & (~out_valid | fire) & ~loaded_all;
    end

    // Status outputs decoded from state; write-back is frozen only while words are being produced
    always_comb begin
        busy    = (state != ST_IDLE);
        done    = (state == ST_DONE);
        rf_hold = (state == ST_STREAM) | (state == ST_CSUM);
`ifdef RF_READOUT_CSUM_EN
        out_is_csum = is_csum_q;
        out_last    = out_valid & is_csum_q;
`else
        out_is_csum = 1'b0;
        out_last    = out_valid & (out_idx == LAST_PTR) & loaded_all;
`endif
    end

    // Sequencer, read pointer and output holding register; abort wins over any fire
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            rd_ptr     <= '0;
            loaded_all <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_idx    <= '0;
`ifdef RF_READOUT_CSUM_EN
            csum       <= '0;
            is_csum_q  <= 1'b0;
`endif
        end else if (state != ST_IDLE && abort) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
`ifdef RF_READOUT_CSUM_EN
            is_csum_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_STREAM;
                        rd_ptr     <= '0;
                        loaded_all <= 1'b0;
                        out_valid  <= 1'b0;
`ifdef RF_READOUT_CSUM_EN
                        csum       <= '0;
`endif
                    end
                end
                ST_STREAM: begin
                    if (load) begin
                        out_data  <= rd_data;
                        out_idx   <= rd_ptr;
                        out_valid <= 1'b1;
`ifdef RF_READOUT_CSUM_EN
                        csum      <= csum ^ rd_data;
`endif
                        if (rd_ptr == LAST_PTR) begin
                            loaded_all <= 1'b1;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end else if (fire && loaded_all) begin
`ifdef RF_READOUT_CSUM_EN
                        state     <= ST_CSUM;
                        out_data  <= csum;
                        out_idx   <= '0;
                        is_csum_q <= 1'b1;
                        out_valid <= 1'b1;
`else
                        state     <= ST_DONE;
                        out_valid <= 1'b0;
`endif
                    end
                end
`ifdef RF_READOUT_CSUM_EN
                ST_CSUM: begin
                    if (fire) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b0;
                        is_csum_q <= 1'b0;
                    end
                end
`endif
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_readout.sv
// tb/tb_rf_readout.sv - directed bench for rf_readout (default build or RF_READOUT_CSUM_EN)
module tb_rf_readout;
    import rf_readout_pkg::*;

    localparam int RC = RF_REG_COUNT;
    localparam int RS = RF_REG_SIZE;
    localparam int RP = RF_REG_PTR_SIZE;
`ifdef RF_READOUT_CSUM_EN
    localparam int EXP_WORDS = RC + 1;
    localparam int EXP_DONE  = 19;
`else
    localparam int EXP_WORDS = RC;
    localparam int EXP_DONE  = 18;
`endif

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          rf_hold;
    logic [RP-1:0] rd_ptr;
    logic [RS-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [RS-1:0] out_data;
    logic [RP-1:0] out_idx;
    logic          out_last;
    logic          out_is_csum;

    logic [RS-1:0] regs [RC];
    int total;
    int bad;

    assign rd_data = regs[rd_ptr];

    rf_readout dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .rf_hold    (rf_hold),
        .rd_ptr     (rd_ptr),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .out_is_csum(out_is_csum)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {busy, done, rf_hold, rd_ptr, out_valid, out_data, out_idx, out_last, out_is_csum}, 64'd0);
    endtask

    // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0 repeating from cycle 2.
    // poke: assert start at cycle 4 (STREAM) and in the DONE cycle; both must be ignored.
    task automatic do_dump(input int mode, input bit poke);
        int            cyc;
        int            nw;
        int            done_cyc;
        int            bad_stable;
        bit            stalled;
        logic [RS-1:0] x;
        logic [RS-1:0] pd;
        logic [RP-1:0] pi;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        check("c1_busy", busy, 1);
        check("c1_hold", rf_hold, 1);
        check("c1_valid", out_valid, 0);
        nw = 0;
        done_cyc = -1;
        bad_stable = 0;
        stalled = 0;
        x = '0;
        pd = '0;
        pi = '0;
        while (done_cyc < 0 && cyc < 200) begin
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 2);
            start = poke && (cyc == 4);
            if (stalled && (out_data !== pd || out_idx !== pi || out_valid !== 1'b1)) bad_stable++;
            if (done) begin
                done_cyc = cyc;
                start = poke;
                check("hold_in_done", rf_hold, 0);
            end else if (out_valid && out_ready) begin
                if (nw < RC) begin
                    check("w_idx", out_idx, nw);
                    check("w_data", out_data, regs[nw]);
                    check("w_csumflag", out_is_csum, 0);
                    x = x ^ regs[nw];
                end else begin
                    check("csum_data", out_data, x);
                    check("csum_flag", out_is_csum, 1);
                end
                check("w_last", out_last, (nw == EXP_WORDS - 1));
                nw++;
            end
            stalled = out_valid && !out_ready;
            pd = out_data;
            pi = out_idx;
            step();
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("done_seen", (done_cyc >= 0), 1);
        if (mode == 0) check("done_cyc", done_cyc, EXP_DONE);
        check("nwords", nw, EXP_WORDS);
        check("stall_stable", bad_stable, 0);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_hold", rf_hold, 0);
    endtask

    // Run a dump with out_ready high until word `idx` is presented; returns whether it was seen.
    task automatic run_to_idx(input int idx, output bit seen);
        int n;
        seen = 0;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!(out_valid && out_idx == RP'(idx)) && n < 40) begin
            step();
            n++;
        end
        seen = out_valid && (out_idx == RP'(idx));
    endtask

    initial begin
        bit seen;
        int dcount;
        total = 0;
        bad = 0;
        reset_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < RC; i++) regs[i] = RS'(i * 3);
        step();
        step();
        check_all_zero("reset_outs");
        reset_n = 1'b1;
        step();
        check("reset_idle", busy, 0);

        do_dump(0, 0);
        do_dump(1, 0);

        run_to_idx(7, seen);
        check("abort_reach7", seen, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_hold", rf_hold, 0);
        check("abort_valid", out_valid, 0);
        check("abort_csum", out_is_csum, 0);
        dcount = done;
        for (int i = 0; i < 4; i++) begin
            step();
            dcount += done;
        end
        check("abort_nodone", dcount, 0);

        do_dump(0, 1);
        do_dump(0, 0);

        run_to_idx(5, seen);
        check("rst_reach5", seen, 1);
        reset_n = 1'b0;
        step();
        check_all_zero("rst_mid_outs");
        reset_n = 1'b1;
        step();
        check("rst_mid_done", done, 0);
        check("rst_mid_busy", busy, 0);
        do_dump(0, 0);

`ifdef RF_READOUT_CSUM_EN
        for (int i = 0; i < RC; i++) regs[i] = RS'(1) << i;
        do_dump(0, 0);
`else
        for (int i = 0; i < RC; i++) regs[i] = RS'(32'hA5A5_0000 + i * 7);
        do_dump(1, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
